// File: rtl/net_argmax_16_16.sv
// Argmax tail stage: folds a serial stream of N signed scores into the index of the largest one.
// Optional macro ARGMAX_SCORE_EN adds the output_score port carrying the winning score.
module net_argmax_16_16 #(
  parameter int N = 16,
  parameter int T = 16,
  localparam int IDXW = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
`ifdef ARGMAX_SCORE_EN
  output logic signed [T-1:0] output_score,
`endif
  output logic [IDXW-1:0]     output_index
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t                state_p0;
  logic [IDXW-1:0]       count_p0;
  logic signed [T-1:0]   best_p0;
  logic [IDXW-1:0]       best_idx_p0;
  logic signed [T-1:0]   score_p1;
  logic [IDXW-1:0]       index_p1;
  logic                  vld_p1;

  logic                  take;
  logic signed [T-1:0]   next_best;
  logic [IDXW-1:0]       next_idx;

  // Strict signed compare; ties never replace, so the lowest index wins.
  function automatic logic score_gt(input logic signed [T-1:0] a,
                                    input logic signed [T-1:0] b);
    return a > b;
  endfunction

  assign input_ready = (state_p0 == ACCUM) && reset;

  always_comb begin
    take      = (count_p0 == '0) || score_gt(input_data, best_p0);
    next_best = take ? input_data : best_p0;
    next_idx  = take ? count_p0 : best_idx_p0;
  end

  // Stage p0: running maximum over accepted beats; p1: held result until handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p0    <= ACCUM;
      count_p0    <= '0;
      best_p0     <= '0;
      best_idx_p0 <= '0;
      vld_p1      <= 1'b0;
      index_p1    <= '0;
      score_p1    <= '0;
    end else begin
      case (state_p0)
        ACCUM: begin
          if (input_valid) begin
            best_p0     <= next_best;
            best_idx_p0 <= next_idx;
            if (count_p0 == LAST_IDX) begin
              state_p0 <= HOLD;
              count_p0 <= '0;
              vld_p1   <= 1'b1;
              index_p1 <= next_idx;
              score_p1 <= next_best;
            end else begin
              count_p0 <= count_p0 + IDXW'(1);
            end
          end
        end
        HOLD: begin
          if (output_ready) begin
            vld_p1   <= 1'b0;
            state_p0 <= ACCUM;
          end
        end
        default: state_p0 <= ACCUM;
      endcase
    end
  end

  assign output_valid = vld_p1;
  assign output_index = index_p1;

`ifdef ARGMAX_SCORE_EN
  assign output_score = score_p1;
`else
  // The held score is only observable when the score port is built.
  logic unused_score;
  assign unused_score = ^score_p1;
`endif

endmodule

// File: tb/tb_net_argmax_16_16.sv
// Directed bench for net_argmax_16_16; checks output_score only when ARGMAX_SCORE_EN is defined.
module tb_net_argmax_16_16;
  localparam int N = 16;
  localparam int T = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                input_valid = 1'b0;
  logic                input_ready;
  logic signed [T-1:0] input_data = '0;
  logic                output_valid;
  logic                output_ready = 1'b0;
  logic [3:0]          output_index;
`ifdef ARGMAX_SCORE_EN
  logic signed [T-1:0] output_score;
`endif

  net_argmax_16_16 #(.N(N), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
`ifdef ARGMAX_SCORE_EN
    .output_score (output_score),
`endif
    .output_index (output_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic signed [T-1:0] vec [N];

  task automatic check(input string tag, input logic [T-1:0] obs, input logic [T-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_score(input string tag, input logic [T-1:0] exp);
`ifdef ARGMAX_SCORE_EN
    check(tag, output_score, exp);
`else
    if (exp === 'x) $display("note: %s", tag);
`endif
  endtask

  // Drive vec[0..N-1]; a set bit in bub inserts one idle cycle before that beat.
  task automatic send_vec(input string tag, input logic [N-1:0] bub,
                          input logic [3:0] exp_idx, input logic [T-1:0] exp_score);
    for (int k = 0; k < N; k++) begin
      if (bub[k]) begin
        @(negedge clk);
        input_valid = 1'b0;
        check({tag, "_bubble_vld"}, {15'd0, output_valid}, 16'd0);
      end
      @(negedge clk);
      if (k == N - 1) check({tag, "_early_vld"}, {15'd0, output_valid}, 16'd0);
      input_valid = 1'b1;
      input_data  = vec[k];
    end
    @(negedge clk);
    input_valid = 1'b0;
    check({tag, "_vld"}, {15'd0, output_valid}, 16'd1);
    check({tag, "_idx"}, {12'd0, output_index}, {12'd0, exp_idx});
    check_score({tag, "_score"}, exp_score);
  endtask

  task automatic take(input string tag);
    output_ready = 1'b1;
    @(negedge clk);
    check({tag, "_vld_drop"}, {15'd0, output_valid}, 16'd0);
    check({tag, "_rdy_back"}, {15'd0, input_ready}, 16'd1);
    output_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_rdy", {15'd0, input_ready}, 16'd0);
    check("rst_out_vld", {15'd0, output_valid}, 16'd0);
    check("rst_idx", {12'd0, output_index}, 16'd0);
    check_score("rst_score", 16'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", {15'd0, input_ready}, 16'd1);

    // 1: ascending scores, output_ready held high
    for (int k = 0; k < N; k++) vec[k] = 16'(k);
    output_ready = 1'b1;
    send_vec("asc", 16'h0000, 4'd15, 16'd15);
    take("asc");

    // 2: tie at 100 on beats 7 and 9 keeps the lower index
    for (int k = 0; k < N; k++) vec[k] = -16'sd5;
    vec[7] = 16'sd100;
    vec[9] = 16'sd100;
    send_vec("tie", 16'h0000, 4'd7, 16'd100);
    take("tie");

    // 3: all most-negative, then all most-positive
    for (int k = 0; k < N; k++) vec[k] = 16'sh8000;
    send_vec("allmin", 16'h0000, 4'd0, 16'h8000);
    take("allmin");
    for (int k = 0; k < N; k++) vec[k] = 16'sh7FFF;
    send_vec("allmax", 16'h0000, 4'd0, 16'h7FFF);
    take("allmax");

    // 4: backpressure for 20 cycles while upstream offers a beat
    for (int k = 0; k < N; k++) vec[k] = 16'(k * 3);
    vec[5] = 16'sd77;
    vec[6] = 16'sd77;
    send_vec("bp_a", 16'h0000, 4'd5, 16'd77);
    for (int k = 0; k < N; k++) vec[k] = 16'(k) - 16'sd20;
    vec[0] = 16'sd500;
    input_valid = 1'b1;
    input_data  = vec[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_hold_vld", {15'd0, output_valid}, 16'd1);
      check("bp_hold_idx", {12'd0, output_index}, 16'd5);
      check("bp_hold_rdy", {15'd0, input_ready}, 16'd0);
    end
    check_score("bp_hold_score", 16'd77);
    output_ready = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    check("bp_rel_vld", {15'd0, output_valid}, 16'd0);
    check("bp_rel_rdy", {15'd0, input_ready}, 16'd1);
    output_ready = 1'b0;
    send_vec("bp_b", 16'h0000, 4'd0, 16'd500);
    take("bp_b");

    // 5: bubbles between beats, maximum 300 at beat 12
    for (int k = 0; k < N; k++) vec[k] = 16'(k * 7) - 16'sd50;
    vec[12] = 16'sd300;
    send_vec("bub", 16'h5A3C, 4'd12, 16'd300);
    take("bub");

    // 6: reset mid-vector discards the partial vector
    for (int k = 0; k < N; k++) vec[k] = 16'(k);
    vec[3] = 16'sd200;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      input_valid = 1'b1;
      input_data  = vec[k];
    end
    @(negedge clk);
    input_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy", {15'd0, input_ready}, 16'd0);
    check("mid_rst_vld", {15'd0, output_valid}, 16'd0);
    check("mid_rst_idx", {12'd0, output_index}, 16'd0);
    check_score("mid_rst_score", 16'd0);
    reset = 1'b1;
    for (int k = 0; k < N; k++) vec[k] = 16'(k) + 16'sd1;
    vec[10] = 16'sd150;
    send_vec("after_rst", 16'h0000, 4'd10, 16'd150);
    take("after_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("single_result", {15'd0, output_valid}, 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
